// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; master drives start and operands,
// slave (the subtractor) returns status and registered results.
interface serial_subtractor_if #(
  parameter int unsigned NUM_BITS = 8
);
  logic                start;
  logic [NUM_BITS-1:0] minuend;
  logic [NUM_BITS-1:0] subtrahend;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] difference;
  logic                borrow_out;
  logic                overflow;

  modport master (
    output start, minuend, subtrahend,
    input  busy, done, difference, borrow_out, overflow
  );

  modport slave (
    input  start, minuend, subtrahend,
    output busy, done, difference, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial minuend - subtrahend, LSB first, one registered borrow stage.
// Define SERIAL_SUB_OVERFLOW_EN to build the signed overflow flag; otherwise it is tied to 0.
module serial_subtractor #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state, state_next;
  logic [NUM_BITS-1:0] a_sr, b_sr, r_sr, diff_q;
  logic [CW-1:0]       count;
  logic                borrow, borrow_q;
  logic                a_i, b_i, d, borrow_next, last;
  logic                busy, done;

  assign a_i         = a_sr[0];
  assign b_i         = b_sr[0];
  assign d           = a_i ^ b_i ^ borrow;
  assign borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow);
  assign last        = (count == CW'(NUM_BITS - 1));

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      diff_q   <= '0;
      count    <= '0;
      borrow   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          a_sr   <= bus.minuend;
          b_sr   <= bus.subtrahend;
          r_sr   <= '0;
          borrow <= 1'b0;
          count  <= '0;
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= {d, r_sr[NUM_BITS-1:1]};
          borrow <= borrow_next;
          count  <= count + CW'(1);
          // Last bit: take the final difference bit directly, r_sr is one shift behind.
          if (last) begin
            diff_q   <= {d, r_sr[NUM_BITS-1:1]};
            borrow_q <= borrow_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q;

  // On the last bit a_i/b_i are the operand MSBs and d is the result MSB.
  always_ff @(posedge clk) begin
    if (!n_rst)                    ovf_q <= 1'b0;
    else if (state == SHIFT && last) ovf_q <= (a_i != b_i) & (d != a_i);
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.difference = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (NUM_BITS=8); honours SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;
  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0] d;
    logic         b;
    logic         o;
    int unsigned  c;
  } res_t;

  logic        clk;
  logic        n_rst;
  int unsigned cyc;
  int          checks;
  int          errors;
  res_t        exp_q[$];
  res_t        obs_q[$];
  res_t        last_exp;

  serial_subtractor_if #(.NUM_BITS(N)) bus ();

  serial_subtractor #(.NUM_BITS(N)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.done === 1'b1)
      obs_q.push_back('{d: bus.difference, b: bus.borrow_out, o: bus.overflow, c: cyc});

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(logic [N-1:0] a, logic [N-1:0] b);
    res_t r;
    int   sd;
    r.d = a - b;
    r.b = (a < b);
    sd  = int'($signed(a)) - int'($signed(b));
`ifdef SERIAL_SUB_OVERFLOW_EN
    r.o = (sd > 127) || (sd < -128);
`else
    r.o = (sd == sd) ? 1'b0 : 1'b1;
`endif
    r.c = 0;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one start strobe; returns at the negedge after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, output int unsigned e0);
    bus.minuend    = a;
    bus.subtrahend = b;
    bus.start      = 1'b1;
    exp_q.push_back(model(a, b));
    tick();
    e0        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.minuend = '0;
    bus.subtrahend = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.difference !== 8'h00) begin errors++; $display("FAIL reset_diff got %h exp 00", bus.difference); end
    checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", bus.borrow_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
  endtask

  task automatic test_basic();
    int unsigned e0;
    int unsigned busy_cnt;
    res_t o, ex;
    busy_cnt = 0;
    issue(8'h5A, 8'h23, e0);
    for (int k = 0; k < int'(N) + 2; k++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
    end
    checks++; if (busy_cnt != N + 1) begin errors++; $display("FAIL basic_busy_cycles got %0d exp %0d", busy_cnt, N + 1); end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL basic_done_count got %0d exp 1", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      o = obs_q.pop_front(); ex = exp_q.pop_front();
      checks++; if (o.c != e0 + N) begin errors++; $display("FAIL basic_latency got %0d exp %0d", o.c - e0, N); end
      checks++; if (o.d !== ex.d) begin errors++; $display("FAIL basic_diff got %h exp %h", o.d, ex.d); end
      checks++; if (o.b !== ex.b) begin errors++; $display("FAIL basic_borrow got %b exp %b", o.b, ex.b); end
      checks++; if (o.o !== ex.o) begin errors++; $display("FAIL basic_ovf got %b exp %b", o.o, ex.o); end
      checks++; if (o.d !== 8'h37) begin errors++; $display("FAIL basic_diff_const got %h exp 37", o.d); end
    end
  endtask

  task automatic run_table(input string name, input logic [2*N-1:0] vecs[]);
    int unsigned e0;
    res_t o, ex;
    foreach (vecs[i]) begin
      issue(vecs[i][2*N-1:N], vecs[i][N-1:0], e0);
      repeat (N + 2) tick();
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        errors++; $display("FAIL %s_done_count[%0d] got %0d exp 1", name, i, obs_q.size());
        obs_q.delete(); exp_q.delete();
      end else begin
        o = obs_q.pop_front(); ex = exp_q.pop_front();
        last_exp = ex;
        checks++; if (o.d !== ex.d) begin errors++; $display("FAIL %s_diff[%0d] got %h exp %h", name, i, o.d, ex.d); end
        checks++; if (o.b !== ex.b) begin errors++; $display("FAIL %s_borrow[%0d] got %b exp %b", name, i, o.b, ex.b); end
        checks++; if (o.o !== ex.o) begin errors++; $display("FAIL %s_ovf[%0d] got %b exp %b", name, i, o.o, ex.o); end
      end
    end
  endtask

  task automatic test_borrow();
    logic [2*N-1:0] v[];
    v = '{16'h00FF, 16'h1010, 16'h0000, 16'hFF00};
    run_table("borrow", v);
  endtask

  task automatic test_overflow();
    logic [2*N-1:0] v[];
    v = '{16'h8001, 16'h7F01};
    run_table("overflow", v);
  endtask

  task automatic test_ignored_start();
    int unsigned e0;
    res_t o1, o2, x1, x2;
    bus.minuend    = 8'h40;
    bus.subtrahend = 8'h05;
    bus.start      = 1'b1;
    exp_q.push_back(model(8'h40, 8'h05));
    tick();
    e0 = cyc;
    repeat (2) tick();
    bus.minuend    = 8'hFF;
    bus.subtrahend = 8'h01;
    exp_q.push_back(model(8'hFF, 8'h01));
    while (cyc < e0 + 19) tick();
    bus.start = 1'b0;
    repeat (4) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b exp 0", bus.busy); end
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL ign_done_count got %0d exp 2", obs_q.size());
      obs_q.delete(); exp_q.delete();
    end else begin
      o1 = obs_q.pop_front(); o2 = obs_q.pop_front();
      x1 = exp_q.pop_front(); x2 = exp_q.pop_front();
      checks++; if (o1.c != e0 + N) begin errors++; $display("FAIL ign_first_latency got %0d exp %0d", o1.c - e0, N); end
      checks++; if (o2.c - o1.c != N + 2) begin errors++; $display("FAIL ign_period got %0d exp %0d", o2.c - o1.c, N + 2); end
      checks++; if (o1.d !== x1.d || o1.b !== x1.b) begin errors++; $display("FAIL ign_first got %h/%b exp %h/%b", o1.d, o1.b, x1.d, x1.b); end
      checks++; if (o2.d !== x2.d || o2.b !== x2.b) begin errors++; $display("FAIL ign_second got %h/%b exp %h/%b", o2.d, o2.b, x2.d, x2.b); end
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 20; k++) begin
      bus.minuend    = N'($urandom);
      bus.subtrahend = N'($urandom);
      bus.start      = 1'b0;
      tick();
      checks++;
      if (bus.difference !== last_exp.d || bus.borrow_out !== last_exp.b ||
          bus.overflow !== last_exp.o || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got %h/%b/%b done %b exp %h/%b/%b done 0", k,
                 bus.difference, bus.borrow_out, bus.overflow, bus.done,
                 last_exp.d, last_exp.b, last_exp.o);
      end
    end
  endtask

  task automatic test_reset_abort();
    int unsigned e0;
    issue(8'h5A, 8'h23, e0);
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b exp 1", bus.busy); end
    n_rst = 1'b0;
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", bus.done); end
    checks++; if (bus.difference !== 8'h00) begin errors++; $display("FAIL abort_diff got %h exp 00", bus.difference); end
    checks++; if (bus.borrow_out !== 1'b0) begin errors++; $display("FAIL abort_borrow got %b exp 0", bus.borrow_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b exp 0", bus.overflow); end
    exp_q.delete();
    n_rst = 1'b1;
    repeat (12) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", obs_q.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_exp = '0;
    test_reset();
    test_basic();
    test_borrow();
    test_ignored_start();
    test_overflow();
    test_hold();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
